memory_stage: RTL and testbench

Pipeline stage directly downstream of execute. Consumes the ALU result, which is the effective address for loads and stores, along with the rs2 store data and the control-signal bundle. For loads and stores it runs a single request/response transaction on the data-memory port, then aligns and extends load data. It hands write-back data and the control bundle to the write-back stage with a one-cycle done pulse.

---
 rtl/mem_stage_pkg.sv | 54 +++++
 rtl/memory_stage_if.sv | 28 ++
 rtl/mem_load_align.sv | 30 +++
 rtl/memory_stage.sv | 191 +++++++++++++++++++
 tb/tb_memory_stage.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: opcode classes, access-size
// encodings, FSM state type, control bundle and lane helper functions.
package mem_stage_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic       reg_write;
    } control_signals_struct;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    // Byte-enable pattern for an access of size 2**sz bytes at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Byte offset rounded down to the natural alignment of the access size.
    function automatic logic [2:0] align_offset(input logic [2:0] off, input logic [1:0] sz);
        logic [2:0] a;
        case (sz)
            2'd0:    a = off;
            2'd1:    a = {off[2:1], 1'b0};
            2'd2:    a = {off[2], 2'b00};
            default: a = 3'b000;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/response port between the memory stage (master)
// and the data memory (slave).
interface memory_stage_if #(
    parameter int DATA_W = 64,
    parameter int STRB_W = 8
);
    import mem_stage_pkg::*;

    logic              dmem_req_valid;
    logic              dmem_req_ready;
    logic [DATA_W-1:0] dmem_req_addr;
    logic              dmem_req_we;
    logic [DATA_W-1:0] dmem_req_wdata;
    logic [STRB_W-1:0] dmem_req_wstrb;
    logic              dmem_resp_valid;
    logic [DATA_W-1:0] dmem_resp_data;

    modport master (
        output dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wdata, dmem_req_wstrb,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_data
    );

    modport slave (
        input  dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wdata, dmem_req_wstrb,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_data
    );

endinterface

// File: rtl/mem_load_align.sv
// Combinational load alignment: shifts the addressed bytes of the returned
// 64-bit word down to lane 0 and sign- or zero-extends them by access size.
module mem_load_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] resp_data,
    input  logic [2:0]        offset,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] load_data
);

    logic [DATA_W-1:0] shifted;

    // Lane shift then size truncation and extension; 011 and 111 are full width.
    always_comb begin
        shifted = resp_data >> {offset, 3'b000};
        case (funct3)
            F3_B:    load_data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
            F3_BU:   load_data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            F3_HU:   load_data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            F3_WU:   load_data = {{(DATA_W-32){1'b0}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: runs one request/response transaction on the data
// memory port for loads and stores, aligns load data, and hands the result
// and control bundle to write-back with a one-cycle memory_done pulse.
// Optional feature macro: MEM_ALIGN_CHECK_EN (flag misaligned H/W/D accesses
// instead of forcing natural alignment).
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int STRB_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_enable,
    input  logic [DATA_W-1:0]     alu_data_in,
    input  logic [DATA_W-1:0]     store_data_in,
    input  control_signals_struct control_signals,
    memory_stage_if.master        dmem,
    output logic [DATA_W-1:0]     wb_data_out,
    output control_signals_struct control_signals_out,
    output logic                  misaligned_out,
    output logic                  memory_done
);

    mem_state_e            state_q, state_d;
    logic                  req_valid_q, req_valid_d;
    logic [DATA_W-1:0]     req_addr_q, req_addr_d;
    logic                  req_we_q, req_we_d;
    logic [DATA_W-1:0]     req_wdata_q, req_wdata_d;
    logic [STRB_W-1:0]     req_wstrb_q, req_wstrb_d;
    control_signals_struct ctrl_q, ctrl_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    control_signals_struct ctrl_out_q, ctrl_out_d;
    logic                  done_q, done_d;
`ifdef MEM_ALIGN_CHECK_EN
    logic                  mis_q, mis_d;
`endif

    logic              is_load_in;
    logic              is_store_in;
    logic              is_mem_in;
    logic [1:0]        size_in;
    logic [2:0]        off_raw;
    logic [2:0]        off_al;
    logic              mis_in;
    logic [DATA_W-1:0] load_val;

    assign is_load_in  = (control_signals.opcode == OPC_LOAD);
    assign is_store_in = (control_signals.opcode == OPC_STORE);
    assign is_mem_in   = is_load_in | is_store_in;
    // Stores use funct3[1:0]; for loads the same two bits give the size (111 -> D).
    assign size_in     = control_signals.funct3[1:0];
    assign off_raw     = alu_data_in[2:0];
    assign off_al      = align_offset(off_raw, size_in);

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_in = is_mem_in && (off_raw != off_al);
`else
    assign mis_in = 1'b0;
`endif

    mem_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .resp_data (dmem.dmem_resp_data),
        .offset    (req_addr_q[2:0]),
        .funct3    (ctrl_q.funct3),
        .load_data (load_val)
    );

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_we_d    = req_we_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        ctrl_d      = ctrl_q;
        wb_data_d   = wb_data_q;
        ctrl_out_d  = ctrl_out_q;
        done_d      = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (mem_enable) begin
                    ctrl_d = control_signals;
                    if (!is_mem_in) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        wb_data_d  = alu_data_in;
                        ctrl_out_d = control_signals;
                    end else if (mis_in) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        wb_data_d  = '0;
                        ctrl_out_d = control_signals;
`ifdef MEM_ALIGN_CHECK_EN
                        mis_d      = 1'b1;
`endif
                    end else begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        req_addr_d  = {alu_data_in[DATA_W-1:3], off_al};
                        req_we_d    = is_store_in;
                        req_wdata_d = store_data_in << {off_al, 3'b000};
                        req_wstrb_d = STRB_W'(size_mask(size_in) << off_al);
                    end
                end
            end
            REQ: begin
                if (dmem.dmem_req_ready) begin
                    req_valid_d = 1'b0;
                    if (req_we_q) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        wb_data_d  = '0;
                        ctrl_out_d = ctrl_q;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem.dmem_resp_valid) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    wb_data_d  = load_val;
                    ctrl_out_d = ctrl_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            ctrl_q      <= '0;
            wb_data_q   <= '0;
            ctrl_out_q  <= '0;
            done_q      <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_we_q    <= req_we_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            ctrl_q      <= ctrl_d;
            wb_data_q   <= wb_data_d;
            ctrl_out_q  <= ctrl_out_d;
            done_q      <= done_d;
`ifdef MEM_ALIGN_CHECK_EN
            mis_q       <= mis_d;
`endif
        end
    end

    assign dmem.dmem_req_valid = req_valid_q;
    assign dmem.dmem_req_addr  = req_addr_q;
    assign dmem.dmem_req_we    = req_we_q;
    assign dmem.dmem_req_wdata = req_wdata_q;
    assign dmem.dmem_req_wstrb = req_wstrb_q;

    assign wb_data_out         = wb_data_q;
    assign control_signals_out = ctrl_out_q;
    assign memory_done         = done_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned_out      = mis_q;
`else
    assign misaligned_out      = 1'b0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: table of transactions driven through a small
// data-memory responder, expected write-back results queued at issue and
// checked when memory_done fires, plus a reset-during-WAIT sequence.
module tb_memory_stage;
    import mem_stage_pkg::*;

    localparam logic [6:0] OPC_ADD = 7'b0110011;

    logic                  clk;
    logic                  reset;
    logic                  mem_enable;
    logic [63:0]           alu_data_in;
    logic [63:0]           store_data_in;
    control_signals_struct control_signals;
    logic [63:0]           wb_data_out;
    control_signals_struct control_signals_out;
    logic                  misaligned_out;
    logic                  memory_done;

    memory_stage_if #(.DATA_W(64), .STRB_W(8)) dmem_if ();

    memory_stage #(.DATA_W(64), .STRB_W(8)) dut (
        .clk                 (clk),
        .reset               (reset),
        .mem_enable          (mem_enable),
        .alu_data_in         (alu_data_in),
        .store_data_in       (store_data_in),
        .control_signals     (control_signals),
        .dmem                (dmem_if),
        .wb_data_out         (wb_data_out),
        .control_signals_out (control_signals_out),
        .misaligned_out      (misaligned_out),
        .memory_done         (memory_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [63:0] resp;
        int          rdy_dly;
        int          resp_dly;
        bit          early;
        bit          poke;
        bit          exp_req;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wstrb;
        bit          exp_we;
        logic [63:0] exp_wb;
        bit          exp_mis;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [63:0]           wb;
        bit                    mis;
        int                    lat;
        control_signals_struct cs;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] sdata,
                                input logic [63:0] resp, input int rdy, input int rsp,
                                input bit early, input bit poke, input bit exp_req,
                                input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                                input logic [7:0] exp_wstrb, input bit exp_we,
                                input logic [63:0] exp_wb, input bit exp_mis, input int exp_lat);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.resp = resp;
        v.rdy_dly = rdy; v.resp_dly = rsp; v.early = early; v.poke = poke;
        v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_wdata = exp_wdata;
        v.exp_wstrb = exp_wstrb; v.exp_we = exp_we; v.exp_wb = exp_wb;
        v.exp_mis = exp_mis; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        exp_t                  e;
        control_signals_struct cs;
        int  n, rdy_cnt, resp_cnt, bad_req;
        bit  done_seen, req_seen, hs_now, in_wait, resp_given, is_load;
        cs.opcode = v.opc; cs.funct3 = v.f3; cs.rd = 5'(idx + 1); cs.reg_write = 1'b1;
        is_load = (v.opc == OPC_LOAD);
        mem_enable = 1'b1;
        alu_data_in = v.addr;
        store_data_in = v.sdata;
        control_signals = cs;
        e.wb = v.exp_wb; e.mis = v.exp_mis; e.lat = v.exp_lat; e.cs = cs;
        sb.push_back(e);
        @(negedge clk);
        n = 1; rdy_cnt = 0; resp_cnt = 0; bad_req = 0;
        done_seen = 0; req_seen = 0; hs_now = 0; in_wait = 0; resp_given = 0;
        while (!done_seen && n <= 60) begin
            mem_enable = 1'b0;
            dmem_if.dmem_resp_valid = 1'b0;
            if (hs_now) begin
                in_wait = 1;
                hs_now = 0;
            end
            if (memory_done) begin
                done_seen = 1;
                dmem_if.dmem_req_ready = 1'b0;
            end else begin
                if (v.poke && n == 1) begin
                    mem_enable = 1'b1;
                    alu_data_in = 64'hDEAD;
                    control_signals.opcode = OPC_ADD;
                end
                if (dmem_if.dmem_req_valid) begin
                    req_seen = 1;
                    if (dmem_if.dmem_req_addr !== v.exp_addr || dmem_if.dmem_req_we !== v.exp_we ||
                        dmem_if.dmem_req_wdata !== v.exp_wdata || dmem_if.dmem_req_wstrb !== v.exp_wstrb)
                        bad_req++;
                    if (rdy_cnt == v.rdy_dly) begin
                        dmem_if.dmem_req_ready = 1'b1;
                        hs_now = 1;
                        if (v.early) begin
                            dmem_if.dmem_resp_valid = 1'b1;
                            dmem_if.dmem_resp_data = ~v.resp;
                        end
                    end else begin
                        dmem_if.dmem_req_ready = 1'b0;
                        rdy_cnt++;
                    end
                end else begin
                    dmem_if.dmem_req_ready = 1'b0;
                end
                if (in_wait && is_load && !resp_given) begin
                    if (resp_cnt == v.resp_dly) begin
                        dmem_if.dmem_resp_valid = 1'b1;
                        dmem_if.dmem_resp_data = v.resp;
                        resp_given = 1;
                    end else begin
                        resp_cnt++;
                    end
                end
                @(negedge clk);
                n++;
            end
        end
        e = sb.pop_front();
        if (!done_seen) begin
            chk($sformatf("v%0d done_timeout", idx), 64'd0, 64'd1);
        end else begin
            chk($sformatf("v%0d wb_data", idx), wb_data_out, e.wb);
            chk($sformatf("v%0d ctrl_out", idx), 64'(control_signals_out), 64'(e.cs));
            chk($sformatf("v%0d misaligned", idx), 64'(misaligned_out), 64'(e.mis));
            chk($sformatf("v%0d latency", idx), 64'(n), 64'(e.lat));
        end
        chk($sformatf("v%0d req_issued", idx), 64'(req_seen), 64'(v.exp_req));
        chk($sformatf("v%0d req_fields", idx), 64'(bad_req), 64'd0);
        @(negedge clk);
        chk($sformatf("v%0d done_pulse_len", idx), 64'(memory_done), 64'd0);
        chk($sformatf("v%0d mis_clear", idx), 64'(misaligned_out), 64'd0);
        chk($sformatf("v%0d wb_hold", idx), wb_data_out, e.wb);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        control_signals_struct cs;
        int done_cnt;
        reset = 1'b0;
        mem_enable = 1'b0;
        alu_data_in = '0;
        store_data_in = '0;
        control_signals = '0;
        dmem_if.dmem_req_ready = 1'b0;
        dmem_if.dmem_resp_valid = 1'b0;
        dmem_if.dmem_resp_data = '0;
        repeat (3) @(negedge clk);
        chk("rst wb_data", wb_data_out, 64'd0);
        chk("rst done", 64'(memory_done), 64'd0);
        chk("rst req_valid", 64'(dmem_if.dmem_req_valid), 64'd0);
        chk("rst ctrl_out", 64'(control_signals_out), 64'd0);
        chk("rst misaligned", 64'(misaligned_out), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        //        opc        f3   addr        sdata                  resp                   rdy rsp e p req addr       wdata                  wstrb  we wb                     mis lat
        vecs.push_back(mk(OPC_ADD,   3'd0, 64'h1234, 64'h0, 64'h0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 8'h00, 0, 64'h1234, 0, 1));
        vecs.push_back(mk(OPC_STORE, 3'd0, 64'h1003, 64'hAB, 64'h0, 3, 0, 0, 1, 1, 64'h1003, 64'hAB00_0000, 8'h08, 1, 64'h0, 0, 5));
        vecs.push_back(mk(OPC_LOAD,  3'd0, 64'h2005, 64'h0, 64'h0000_8000_0000_0000, 0, 0, 0, 0, 1, 64'h2005, 64'h0, 8'h20, 0,
                          64'hFFFF_FFFF_FFFF_FF80, 0, 3));
        vecs.push_back(mk(OPC_LOAD,  3'd4, 64'h2005, 64'h0, 64'h0000_8000_0000_0000, 1, 2, 0, 0, 1, 64'h2005, 64'h0, 8'h20, 0,
                          64'h80, 0, 6));
        vecs.push_back(mk(OPC_LOAD,  3'd2, 64'h2004, 64'h0, 64'h8000_0001_DEAD_BEEF, 0, 0, 1, 0, 1, 64'h2004, 64'h0, 8'hF0, 0,
                          64'hFFFF_FFFF_8000_0001, 0, 3));
        vecs.push_back(mk(OPC_LOAD,  3'd6, 64'h2004, 64'h0, 64'h8000_0001_DEAD_BEEF, 2, 0, 0, 0, 1, 64'h2004, 64'h0, 8'hF0, 0,
                          64'h8000_0001, 0, 5));
`ifdef MEM_ALIGN_CHECK_EN
        vecs.push_back(mk(OPC_LOAD,  3'd1, 64'h3001, 64'h0, 64'h0000_0000_0000_F00D, 0, 0, 0, 0, 0, 64'h0, 64'h0, 8'h00, 0,
                          64'h0, 1, 1));
`else
        vecs.push_back(mk(OPC_LOAD,  3'd1, 64'h3001, 64'h0, 64'h0000_0000_0000_F00D, 0, 0, 0, 0, 1, 64'h3000, 64'h0, 8'h03, 0,
                          64'hFFFF_FFFF_FFFF_F00D, 0, 3));
`endif
        vecs.push_back(mk(OPC_STORE, 3'd3, 64'h4000, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, 0, 0, 1, 64'h4000,
                          64'h0123_4567_89AB_CDEF, 8'hFF, 1, 64'h0, 0, 2));
        vecs.push_back(mk(OPC_STORE, 3'd1, 64'h4006, 64'h1111_2222_3333_BEEF, 64'h0, 1, 0, 0, 0, 1, 64'h4006,
                          64'hBEEF_0000_0000_0000, 8'hC0, 1, 64'h0, 0, 3));
        vecs.push_back(mk(OPC_LOAD,  3'd3, 64'h5000, 64'h0, 64'h8877_6655_4433_2211, 0, 0, 0, 0, 1, 64'h5000, 64'h0, 8'hFF, 0,
                          64'h8877_6655_4433_2211, 0, 3));
        vecs.push_back(mk(OPC_LOAD,  3'd7, 64'h5008, 64'h0, 64'hCAFE_BABE_1234_5678, 0, 0, 0, 0, 1, 64'h5008, 64'h0, 8'hFF, 0,
                          64'hCAFE_BABE_1234_5678, 0, 3));
        vecs.push_back(mk(OPC_LOAD,  3'd5, 64'h6006, 64'h0, 64'hABCD_0000_0000_0000, 0, 1, 0, 0, 1, 64'h6006, 64'h0, 8'hC0, 0,
                          64'hABCD, 0, 4));
`ifdef MEM_ALIGN_CHECK_EN
        vecs.push_back(mk(OPC_STORE, 3'd2, 64'h7006, 64'h1122_3344, 64'h0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 8'h00, 0,
                          64'h0, 1, 1));
        vecs.push_back(mk(OPC_LOAD,  3'd3, 64'h5003, 64'h0, 64'h0102_0304_0506_0708, 0, 0, 0, 0, 0, 64'h0, 64'h0, 8'h00, 0,
                          64'h0, 1, 1));
`else
        vecs.push_back(mk(OPC_STORE, 3'd2, 64'h7006, 64'h1122_3344, 64'h0, 0, 0, 0, 0, 1, 64'h7004,
                          64'h1122_3344_0000_0000, 8'hF0, 1, 64'h0, 0, 2));
        vecs.push_back(mk(OPC_LOAD,  3'd3, 64'h5003, 64'h0, 64'h0102_0304_0506_0708, 0, 0, 0, 0, 1, 64'h5000, 64'h0, 8'hFF, 0,
                          64'h0102_0304_0506_0708, 0, 3));
`endif
        vecs.push_back(mk(OPC_ADD,   3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 8'h00, 0,
                          64'hFFFF_FFFF_FFFF_FFFF, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Reset while waiting for a load response; the late response must be dropped.
        cs.opcode = OPC_LOAD; cs.funct3 = 3'd0; cs.rd = 5'd9; cs.reg_write = 1'b1;
        mem_enable = 1'b1;
        alu_data_in = 64'h2005;
        store_data_in = 64'h0;
        control_signals = cs;
        @(negedge clk);
        mem_enable = 1'b0;
        chk("rstwait req_valid", 64'(dmem_if.dmem_req_valid), 64'd1);
        dmem_if.dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_if.dmem_req_ready = 1'b0;
        chk("rstwait in_wait", 64'(dmem_if.dmem_req_valid), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        dmem_if.dmem_resp_valid = 1'b1;
        dmem_if.dmem_resp_data = 64'h0000_8000_0000_0000;
        chk("rstwait wb_zero", wb_data_out, 64'd0);
        chk("rstwait ctrl_zero", 64'(control_signals_out), 64'd0);
        @(negedge clk);
        dmem_if.dmem_resp_valid = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (memory_done) done_cnt++;
            @(negedge clk);
        end
        chk("rstwait no_done", 64'(done_cnt), 64'd0);
        chk("rstwait wb_still_zero", wb_data_out, 64'd0);
        chk("rstwait req_valid_low", 64'(dmem_if.dmem_req_valid), 64'd0);

        run_vec(mk(OPC_ADD, 3'd0, 64'h55, 64'h0, 64'h0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 8'h00, 0, 64'h55, 0, 1), 99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
